// File: rtl/scan_chain_shifter_if.sv
// Command, TX-write and RX-read bus of the scan-chain shifter.
// master = SW register side, slave = shifter.
interface scan_chain_shifter_if #(
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_data;
    logic          tx_wr_en;
    logic [AW-1:0] tx_wr_addr;
    logic [31:0]   tx_wr_data;
    logic [AW-1:0] rx_rd_addr;
    logic [31:0]   rx_rd_data;

    modport master (
        output cmd_valid, cmd_data, tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
        input  cmd_ready, rx_rd_data
    );

    modport slave (
        input  cmd_valid, cmd_data, tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
        output cmd_ready, rx_rd_data
    );
endinterface

// File: rtl/scan_chain_shifter.sv
// Scan-chain engine: serialises the TX buffer LSB-first onto scan_in, drives
// bxclk and scan_load, and captures scan_out into the RX buffer.
// Optional: SCAN_CHAIN_SHIFTER_LOOPBACK_EN lets cmd_data[22] route the
// registered scan_in into the capture path instead of scan_out.
module scan_chain_shifter #(
    parameter int DEPTH   = 4,
    parameter int NBITS_W = 12
) (
    input  logic               pl_clk1,
    input  logic               reset,
    scan_chain_shifter_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic [NBITS_W-1:0] bit_cnt,
    output logic               scan_in,
    output logic               scan_load,
    output logic               bxclk,
    input  logic               scan_out
);
    localparam int TOTAL = DEPTH * 32;
    localparam int IW    = $clog2(TOTAL);

    typedef enum logic [2:0] {IDLE, LOAD_PRE, SHIFT_LO, SHIFT_HI, LOAD_POST, DONE} state_t;

    state_t             state;
    logic [TOTAL-1:0]   tx_bits;
    logic [TOTAL-1:0]   rx_bits;
    logic [NBITS_W-1:0] nbits_q, nbits_in, cnt_nxt;
    logic [7:0]         half_q, half_in, hcnt;
    logic               pre_in, post_in, post_q, lb_q;
    logic               accept, cap_bit;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign nbits_in = (bus.cmd_data[NBITS_W-1:0] > NBITS_W'(TOTAL)) ? NBITS_W'(TOTAL)
                                                                    : bus.cmd_data[NBITS_W-1:0];
    assign half_in  = (bus.cmd_data[19:12] == 8'd0) ? 8'd1 : bus.cmd_data[19:12];
    assign pre_in   = bus.cmd_data[20];
    assign post_in  = bus.cmd_data[21];
    assign cnt_nxt  = bit_cnt + NBITS_W'(1);

`ifdef SCAN_CHAIN_SHIFTER_LOOPBACK_EN
    // Loopback captures what we actually drove, so it checks the TX path end to end.
    assign cap_bit = lb_q ? scan_in : scan_out;
    logic unused_bits;
    assign unused_bits = ^bus.cmd_data[31:23];
`else
    assign cap_bit = scan_out;
    logic unused_bits;
    assign unused_bits = ^{bus.cmd_data[31:23], lb_q};
`endif

    // TX buffer: SW writes only while idle so a running shift sees stable data.
    always_ff @(posedge pl_clk1) begin
        if (bus.tx_wr_en && !busy)
            tx_bits[{bus.tx_wr_addr, 5'd0} +: 32] <= bus.tx_wr_data;
    end

    // RX read port, one cycle latency; partial data is visible while busy.
    always_ff @(posedge pl_clk1) begin
        if (reset) bus.rx_rd_data <= 32'd0;
        else       bus.rx_rd_data <= rx_bits[{bus.rx_rd_addr, 5'd0} +: 32];
    end

    // Control FSM; every pin-facing output is set on the transition into its state.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            bit_cnt       <= '0;
            scan_in       <= 1'b0;
            scan_load     <= 1'b0;
            bxclk         <= 1'b0;
            hcnt          <= 8'd0;
            nbits_q       <= '0;
            half_q        <= 8'd1;
            post_q        <= 1'b0;
            lb_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.cmd_ready <= 1'b0;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    bit_cnt       <= '0;
                    nbits_q       <= nbits_in;
                    half_q        <= half_in;
                    post_q        <= post_in;
                    lb_q          <= bus.cmd_data[22];
                    hcnt          <= half_in - 8'd1;
                    if (pre_in) begin
                        state <= LOAD_PRE; scan_load <= 1'b1;
                    end else if (nbits_in != '0) begin
                        state <= SHIFT_LO; scan_in <= tx_bits[0];
                    end else if (post_in) begin
                        state <= LOAD_POST; scan_load <= 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                LOAD_PRE: if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
                else begin
                    scan_load <= 1'b0;
                    hcnt      <= half_q - 8'd1;
                    if (nbits_q != '0) begin
                        state <= SHIFT_LO; scan_in <= tx_bits[0];
                    end else if (post_q) begin
                        state <= LOAD_POST; scan_load <= 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                SHIFT_LO: if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
                else begin
                    state <= SHIFT_HI;
                    bxclk <= 1'b1;
                    hcnt  <= half_q - 8'd1;
                end
                SHIFT_HI: if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
                else begin
                    // Capture on the last high cycle, just before the falling edge.
                    bxclk                   <= 1'b0;
                    rx_bits[bit_cnt[IW-1:0]] <= cap_bit;
                    bit_cnt                 <= cnt_nxt;
                    hcnt                    <= half_q - 8'd1;
                    if (cnt_nxt < nbits_q) begin
                        state <= SHIFT_LO; scan_in <= tx_bits[cnt_nxt[IW-1:0]];
                    end else if (post_q) begin
                        state <= LOAD_POST; scan_load <= 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                LOAD_POST: if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
                else begin
                    scan_load <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state         <= IDLE;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    scan_in       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_shifter.sv
// Scoreboard bench for scan_chain_shifter: stimulus pushes expected scan bits,
// completion records and RX words; a negedge monitor pops and compares.
module tb_scan_chain_shifter;
    logic        pl_clk1 = 1'b0;
    logic        reset;
    logic        busy, done, scan_in, scan_load, bxclk, scan_out;
    logic [11:0] bit_cnt;
    logic        lb_mode, so_val, rd_req, rd_q;

    always #5 pl_clk1 = ~pl_clk1;

    scan_chain_shifter_if #(.DEPTH(4)) bus ();

    scan_chain_shifter #(.DEPTH(4), .NBITS_W(12)) dut (
        .pl_clk1(pl_clk1), .reset(reset), .bus(bus),
        .busy(busy), .done(done), .bit_cnt(bit_cnt), .scan_in(scan_in),
        .scan_load(scan_load), .bxclk(bxclk), .scan_out(scan_out)
    );

    // External chain model: either a wire back from scan_in or a constant level.
    assign scan_out = lb_mode ? scan_in : so_val;

    typedef struct {
        int cnt; int lat; int bxr; int bxh; int ld;
    } done_t;

    bit          exp_bits[$];
    done_t       exp_done[$];
    logic [31:0] exp_rx[$];
    logic [31:0] tx_model[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge pl_clk1) rd_q <= rd_req;

    // Monitor: pops expectations whenever the DUT presents a bxclk rise, a done rise or read data.
    bit prev_bx, prev_done, acc_seen;
    int cyc, n_bxr, n_bxh, n_ld;
    always @(negedge pl_clk1) begin
        if (reset) begin
            prev_bx = 0; prev_done = 0; acc_seen = 0;
        end else begin
            if (acc_seen) begin cyc = 1; n_bxr = 0; n_bxh = 0; n_ld = 0; end
            else cyc++;
            if (bxclk) n_bxh++;
            if (scan_load) n_ld++;
            if (bxclk && !prev_bx) begin
                n_bxr++;
                if (exp_bits.size() == 0) chk("bit_extra", 32'd1, 32'd0);
                else chk("scan_in_bit", {31'd0, scan_in}, {31'd0, exp_bits.pop_front()});
            end
            if (done && !prev_done) begin
                if (exp_done.size() == 0) chk("done_extra", 32'd1, 32'd0);
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_bit_cnt", {20'd0, bit_cnt}, d.cnt);
                    if (d.lat >= 0) chk("done_latency", cyc, d.lat);
                    chk("bxclk_rises", n_bxr, d.bxr);
                    chk("bxclk_hi_cycles", n_bxh, d.bxh);
                    chk("scan_load_cycles", n_ld, d.ld);
                end
            end
            if (rd_q) begin
                if (exp_rx.size() == 0) chk("rx_extra", 32'd1, 32'd0);
                else chk("rx_rd_data", bus.rx_rd_data, exp_rx.pop_front());
            end
            prev_bx = bxclk; prev_done = done;
            acc_seen = bus.cmd_valid && bus.cmd_ready;
        end
    end

    task automatic tick();
        @(posedge pl_clk1); #1;
    endtask

    task automatic tx_wr(input int a, input logic [31:0] d);
        bus.tx_wr_en = 1; bus.tx_wr_addr = 2'(a); bus.tx_wr_data = d;
        tx_model[a] = d;
        tick();
        bus.tx_wr_en = 0;
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        bus.rx_rd_addr = 2'(a); rd_req = 1; exp_rx.push_back(e);
        tick();
        rd_req = 0;
    endtask

    task automatic issue(input int nb, input int hd, input bit pre, input bit post,
                         input bit lb, input int lat, input bit auto_bits);
        int t;
        logic [31:0] w;
        done_t d;
        int h;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin tick(); t++; end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        if (auto_bits)
            for (int i = 0; i < nb; i++) begin
                w = tx_model[i / 32];
                exp_bits.push_back(w[i % 32]);
            end
        h = (hd == 0) ? 1 : hd;
        d.cnt = nb; d.lat = lat; d.bxr = nb; d.bxh = nb * h; d.ld = (int'(pre) + int'(post)) * h;
        exp_done.push_back(d);
        bus.cmd_data = {9'd0, lb, post, pre, 8'(hd), 12'(nb)};
        bus.cmd_valid = 1;
        tick();
        bus.cmd_valid = 0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 1000) begin tick(); t++; end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1; lb_mode = 0; so_val = 0; rd_req = 0;
        bus.cmd_valid = 0; bus.cmd_data = 0; bus.tx_wr_en = 0;
        bus.tx_wr_addr = 0; bus.tx_wr_data = 0; bus.rx_rd_addr = 0;

        // Reset state
        repeat (3) @(posedge pl_clk1);
        @(negedge pl_clk1);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bxclk", {31'd0, bxclk}, 32'd0);
        chk("rst_scan_in", {31'd0, scan_in}, 32'd0);
        chk("rst_scan_load", {31'd0, scan_load}, 32'd0);
        chk("rst_bit_cnt", {20'd0, bit_cnt}, 32'd0);
        tick();
        reset = 0;

        // Full 128-bit chain looped back: RX must mirror TX
        tx_wr(0, 32'hDEADBEEF); tx_wr(1, 32'h12345678);
        tx_wr(2, 32'hCAFEF00D); tx_wr(3, 32'h0F0F0F0F);
        lb_mode = 1;
        issue(128, 1, 0, 0, 1, 258, 1);
        wait_done();
        rd(0, 32'hDEADBEEF); rd(1, 32'h12345678); rd(2, 32'hCAFEF00D); rd(3, 32'h0F0F0F0F);

        // 0xA5, 8 bits LSB-first, scan_out held low
        lb_mode = 0; so_val = 0;
        tx_wr(0, 32'h000000A5);
        exp_bits.push_back(1); exp_bits.push_back(0); exp_bits.push_back(1); exp_bits.push_back(0);
        exp_bits.push_back(0); exp_bits.push_back(1); exp_bits.push_back(0); exp_bits.push_back(1);
        issue(8, 1, 0, 0, 0, 18, 0);
        wait_done();
        chk("bit_cnt_8", {20'd0, bit_cnt}, 32'd8);
        rd(0, 32'hDEADBE00); rd(1, 32'h12345678);

        // Load pre/post with half=3, scan_out held high
        so_val = 1;
        issue(2, 3, 1, 1, 0, 20, 1);
        wait_done();
        rd(0, 32'hDEADBE03);

        // nbits=0, then a command dropped while busy
        issue(0, 1, 0, 0, 0, 2, 1);
        wait_done();
        issue(16, 1, 0, 0, 0, 34, 1);
        repeat (3) tick();
        chk("busy_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        bus.cmd_data = {9'd0, 1'b0, 1'b1, 1'b1, 8'd2, 12'd3};
        bus.cmd_valid = 1; bus.tx_wr_en = 1; bus.tx_wr_addr = 0; bus.tx_wr_data = 32'hFFFFFFFF;
        tick();
        bus.cmd_valid = 0; bus.tx_wr_en = 0;
        wait_done();
        chk("bit_cnt_16", {20'd0, bit_cnt}, 32'd16);

        // Reset mid-shift at bit 5 of 32, then a clean 4-bit command
        issue(32, 1, 0, 0, 0, -1, 1);
        begin
            int t;
            t = 0;
            while (bit_cnt != 12'd5 && t < 200) begin tick(); t++; end
            if (bit_cnt != 12'd5) chk("bit5_timeout", {20'd0, bit_cnt}, 32'd5);
        end
        reset = 1;
        exp_bits.delete(); exp_done.delete();
        @(posedge pl_clk1);
        @(negedge pl_clk1);
        chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bxclk", {31'd0, bxclk}, 32'd0);
        chk("abort_scan_in", {31'd0, scan_in}, 32'd0);
        chk("abort_scan_load", {31'd0, scan_load}, 32'd0);
        chk("abort_bit_cnt", {20'd0, bit_cnt}, 32'd0);
        chk("abort_rx_rd_data", bus.rx_rd_data, 32'd0);
        tick();
        reset = 0;
        issue(4, 1, 0, 0, 0, 10, 1);
        wait_done();
        repeat (4) tick();

        chk("bits_left", exp_bits.size(), 32'd0);
        chk("done_left", exp_done.size(), 32'd0);
        chk("rx_left", exp_rx.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
